// File: rtl/alu_mp_sequencer_if.sv
// Bundle between the instruction control, operand/result storage and the shared ALU
// for the multi-precision sequencer.
interface alu_mp_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 2
);
  logic              start;
  logic [1:0]        op;
  logic [IDX_W:0]    len;
  logic              cin;
  logic              abort;
  logic [IDX_W-1:0]  opd_idx;
  logic [DATA_W-1:0] opd_a;
  logic [DATA_W-1:0] opd_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_sub;
  logic              alu_sbb;
  logic              alu_adc;
  logic              alu_c;
  logic [DATA_W-1:0] alu_y;
  logic              alu_cout;
  logic              res_we;
  logic [IDX_W-1:0]  res_idx;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              done;
  logic              carry_out;
  logic              zero;
  logic              err;

  modport slave (
    input  start, op, len, cin, abort, opd_a, opd_b, alu_y, alu_cout,
    output opd_idx, alu_a, alu_b, alu_sub, alu_sbb, alu_adc, alu_c,
           res_we, res_idx, res_data, busy, done, carry_out, zero, err
  );

  modport master (
    output start, op, len, cin, abort, opd_a, opd_b, alu_y, alu_cout,
    input  opd_idx, alu_a, alu_b, alu_sub, alu_sbb, alu_adc, alu_c,
           res_we, res_idx, res_data, busy, done, carry_out, zero, err
  );
endinterface

// File: rtl/alu_mp_sequencer.sv
// Word-serial multi-precision ADD/ADC/SUB/SBB sequencer driving a shared ALU,
// least-significant word first, carrying the ALU carry between words.
module alu_mp_sequencer #(
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_mp_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_WORDS);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             zacc;
  logic             err_r;

  logic [1:0]       op_r;
  logic             cin_r;
  logic [IDX_W-1:0] last_idx;

  logic run;
  logic len_ok;
  logic first;
  logic sub_first;

  assign run       = (state == S_RUN);
  assign len_ok    = (bus.len != '0) && (bus.len <= LEN_MAX);
  assign first     = (idx == '0);
  assign sub_first = (op_r == OP_SUB) && first;

  // Control state: FSM, word index, inter-word carry and zero accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              state <= S_RUN;
              idx   <= '0;
              zacc  <= 1'b1;
              err_r <= 1'b0;
            end else begin
              state <= S_DONE;
              carry <= 1'b0;
              zacc  <= 1'b0;
              err_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            carry <= bus.alu_cout;
            zacc  <= zacc & (bus.alu_y == '0);
            idx   <= idx + IDX_W'(1);
            if (idx == last_idx) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operation descriptor, captured on an accepted start; only read while running
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && bus.start) begin
      op_r     <= bus.op;
      cin_r    <= bus.cin;
      last_idx <= bus.len[IDX_W-1:0] - IDX_W'(1);
    end
  end

  assign bus.opd_idx = run ? idx : '0;
  assign bus.alu_a   = run ? bus.opd_a : '0;
  assign bus.alu_b   = run ? bus.opd_b : '0;

  // Word 0 of SUB is a plain subtract; every other subtract word chains the borrow
  assign bus.alu_adc = run & ~op_r[1];
  assign bus.alu_sub = run & sub_first;
  assign bus.alu_sbb = run & op_r[1] & ~sub_first;
  assign bus.alu_c   = run & (first ? (op_r[0] & cin_r) : carry);

  assign bus.res_we   = run & ~bus.abort;
  assign bus.res_idx  = run ? idx : '0;
  assign bus.res_data = run ? bus.alu_y : '0;

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.carry_out = bus.done & carry;
  assign bus.zero      = bus.done & zacc;
  assign bus.err       = bus.done & err_r;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Scoreboard bench for alu_mp_sequencer: directed multi-word operations against a
// behavioural ALU, expected writes and completions queued and checked by a monitor.
module tb_alu_mp_sequencer;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
    logic [3:0]  mode;   // {sub, sbb, adc, c}
  } wr_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic err;
  } dn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wr_t  wr_q[$];
  dn_t  dn_q[$];

  logic [15:0] a_mem [4];
  logic [15:0] b_mem [4];
  logic [16:0] alu_s;

  always #5 clk = ~clk;

  alu_mp_sequencer_if #(.DATA_W(16), .IDX_W(2)) bus ();

  alu_mp_sequencer #(.DATA_W(16), .MAX_WORDS(4), .IDX_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.opd_a = a_mem[bus.opd_idx];
  assign bus.opd_b = b_mem[bus.opd_idx];

  // Shared ALU: subtraction carry is NOT borrow
  always_comb begin
    alu_s = '0;
    if (bus.alu_adc)
      alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 17'(bus.alu_c);
    else if (bus.alu_sbb)
      alu_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'(bus.alu_c);
    else if (bus.alu_sub)
      alu_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
  end
  assign bus.alu_y    = alu_s[15:0];
  assign bus.alu_cout = alu_s[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [1:0] i, input logic [15:0] d, input logic [3:0] m);
    wr_t w;
    w.idx = i; w.data = d; w.mode = m;
    wr_q.push_back(w);
  endtask

  task automatic push_dn(input logic c, input logic z, input logic e);
    dn_t d;
    d.carry = c; d.zero = z; d.err = e;
    dn_q.push_back(d);
  endtask

  task automatic check_idle(input string name);
    chk(name, {2'b0, bus.opd_idx, bus.alu_a, bus.alu_b, bus.alu_sub, bus.alu_sbb,
               bus.alu_adc, bus.alu_c, bus.res_we, bus.res_idx, bus.res_data,
               bus.busy, bus.done, bus.carry_out, bus.zero, bus.err}, 64'd0);
  endtask

  task automatic set_words(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    a_mem[0] = a0; a_mem[1] = a1; a_mem[2] = a2; a_mem[3] = a3;
    b_mem[0] = b0; b_mem[1] = b1; b_mem[2] = b2; b_mem[3] = b3;
  endtask

  // Issue one START; hold keeps START high for that many extra edges to probe BUSY masking
  task automatic issue(input string name, input logic [1:0] o, input logic [2:0] l,
                       input logic c, input int hold, input int exp_lat);
    int cyc;
    @(posedge clk); #1;
    bus.op = o; bus.len = l; bus.cin = c; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (hold < 1) bus.start = 1'b0;
    while (!bus.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > hold) bus.start = 1'b0;
    end
    if (hold > 0 && bus.start) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  // Monitor: every write strobe and completion pulse is matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual idx=%0d data=0x%0h required no write",
                   bus.res_idx, bus.res_data);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_idx",  64'(bus.res_idx), 64'(e.idx));
          chk("wr_data", 64'(bus.res_data), 64'(e.data));
          chk("wr_mode", 64'({bus.alu_sub, bus.alu_sbb, bus.alu_adc, bus.alu_c}), 64'(e.mode));
        end
      end
      if (bus.done) begin
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual done=1 required done=0");
        end else begin
          dn_t e;
          e = dn_q.pop_front();
          if (e.err) chk("done_err", 64'(bus.err), 64'd1);
          else       chk("done_flags", 64'({bus.carry_out, bus.zero, bus.err}), 64'(e));
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.len = '0; bus.cin = 1'b0; bus.abort = 1'b0;
    set_words(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1 check_idle("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1 check_idle("idle_after_reset");

    // ADD, 2 words: FFFF+0001 ripples a carry into word 1
    set_words(16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0001, 16'h0000, 16'h0, 16'h0);
    push_wr(2'd0, 16'h0000, 4'b0010);
    push_wr(2'd1, 16'h0002, 4'b0011);
    push_dn(1'b0, 1'b0, 1'b0);
    issue("add2", 2'b00, 3'd2, 1'b0, 0, 3);

    // SUB, 2 words: borrow out of word 0 reaches word 1 as ALU_C=0
    set_words(16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0001, 16'h0000, 16'h0, 16'h0);
    push_wr(2'd0, 16'hFFFF, 4'b1000);
    push_wr(2'd1, 16'h0000, 4'b0100);
    push_dn(1'b1, 1'b0, 1'b0);
    issue("sub2", 2'b10, 3'd2, 1'b0, 0, 3);

    // SUB, 4 equal words: all-zero result
    set_words(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    push_wr(2'd0, 16'h0000, 4'b1000);
    push_wr(2'd1, 16'h0000, 4'b0101);
    push_wr(2'd2, 16'h0000, 4'b0101);
    push_wr(2'd3, 16'h0000, 4'b0101);
    push_dn(1'b1, 1'b1, 1'b0);
    issue("sub4", 2'b10, 3'd4, 1'b0, 0, 5);

    // ADC, 1 word with CIN=1, START held high through the run and DONE cycle
    set_words(16'h4567, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0);
    push_wr(2'd0, 16'h579C, 4'b0011);
    push_dn(1'b0, 1'b0, 1'b0);
    issue("adc1", 2'b01, 3'd1, 1'b1, 2, 2);
    repeat (4) @(posedge clk);
    #1 chk("adc1_no_restart_busy", 64'(bus.busy), 64'd0);

    // SBB, 3 words with CIN=0: borrow-in propagates through every word
    set_words(16'h0005, 16'h0000, 16'h0000, 16'h0, 16'h0005, 16'h0000, 16'h0000, 16'h0);
    push_wr(2'd0, 16'hFFFF, 4'b0100);
    push_wr(2'd1, 16'hFFFF, 4'b0100);
    push_wr(2'd2, 16'hFFFF, 4'b0100);
    push_dn(1'b0, 1'b0, 1'b0);
    issue("sbb3", 2'b11, 3'd3, 1'b0, 0, 4);

    // Out-of-range lengths
    push_dn(1'b0, 1'b0, 1'b1);
    issue("len0", 2'b00, 3'd0, 1'b0, 0, 1);
    push_dn(1'b0, 1'b0, 1'b1);
    issue("len5", 2'b00, 3'd5, 1'b0, 0, 1);

    // ABORT during word 2 of a 4-word ADD
    set_words(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0);
    push_wr(2'd0, 16'h0001, 4'b0010);
    push_wr(2'd1, 16'h0002, 4'b0010);
    @(posedge clk); #1;
    bus.op = 2'b00; bus.len = 3'd4; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.abort = 1'b1;
    #1 chk("abort_we_suppressed", 64'(bus.res_we), 64'd0);
    @(posedge clk); #1 bus.abort = 1'b0;
    check_idle("after_abort");
    repeat (3) @(posedge clk);
    #1 check_idle("after_abort_settled");

    // Reset during word 1 of a 4-word ADD
    push_wr(2'd0, 16'h0001, 4'b0010);
    @(posedge clk); #1;
    bus.op = 2'b00; bus.len = 3'd4; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_idle("in_reset_mid_run");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("after_reset_mid_run");
    repeat (3) @(posedge clk);
    #1 check_idle("after_reset_settled");

    // Recovery: single-word ADD wrapping to zero with carry out
    set_words(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0);
    push_wr(2'd0, 16'h0000, 4'b0010);
    push_dn(1'b1, 1'b1, 1'b0);
    issue("add1_wrap", 2'b00, 3'd1, 1'b0, 0, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("done_queue_drained", 64'(dn_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
